// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes,
// default latencies and the two-state FSM encoding.
package e_mdu_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 16;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // Ops 0-3 occupy the unit for a multi-cycle latency.
    function automatic logic is_muldiv(input logic [2:0] op);
        return op <= 3'd3;
    endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Results are computed combinationally from
// latched operands; a down-counter models the latency before HI/LO commit.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_rs_data,
    input  logic [31:0] E_rt_data,
    output logic        E_md_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    // Valid/ready: an op is accepted on a rising edge where E_start is high
    // and the unit is IDLE; while BUSY (E_md_busy=1) E_start is dropped.
    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [31:0]      a_q, b_q;

    logic        accept, finish, mt_hi, mt_lo;
    logic        res_valid;
    logic [31:0] res_hi, res_lo;

    assign accept = (state == ST_IDLE) && E_start && is_muldiv(E_md_op);
    assign mt_hi  = (state == ST_IDLE) && E_start && (E_md_op == MD_MTHI);
    assign mt_lo  = (state == ST_IDLE) && E_start && (E_md_op == MD_MTLO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_BUSY;
            ST_BUSY: if (cnt <= CNT_W'(1)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        E_md_busy = (state == ST_BUSY);
        finish    = (state == ST_BUSY) && (cnt <= CNT_W'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            cnt  <= (E_md_op <= 3'd1) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            op_q <= E_md_op;
            a_q  <= E_rs_data;
            b_q  <= E_rt_data;
        end else if (state == ST_BUSY && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] div_u_safe, div_s_safe;
    logic               div_ovf;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // A zero divisor never commits, so substituting 1 only avoids X in sim.
    // The one signed overflow case divides by 1 instead, which yields the
    // architected 0x80000000 quotient and zero remainder.
    assign div_ovf    = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign div_u_safe = (b_q == 32'd0) ? 32'd1 : b_q;
    assign div_s_safe = div_ovf ? 32'd1 : div_u_safe;

    always_comb begin
        res_valid = 1'b0;
        res_hi    = '0;
        res_lo    = '0;
        case (op_q)
            MD_MULT: begin
                res_valid = 1'b1;
                {res_hi, res_lo} = prod_s;
            end
            MD_MULTU: begin
                res_valid = 1'b1;
                {res_hi, res_lo} = prod_u;
            end
            MD_DIV: begin
                res_valid = (b_q != 32'd0);
                res_lo    = $signed(a_q) / $signed(div_s_safe);
                res_hi    = $signed(a_q) % $signed(div_s_safe);
            end
            MD_DIVU: begin
                res_valid = (b_q != 32'd0);
                res_lo    = a_q / div_u_safe;
                res_hi    = a_q % div_u_safe;
            end
            default: res_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            E_HI <= '0;
            E_LO <= '0;
        end else if (finish) begin
            if (res_valid) begin
                E_HI <= res_hi;
                E_LO <= res_lo;
            end
        end else begin
            if (mt_hi) E_HI <= E_rs_data;
            if (mt_lo) E_LO <= E_rs_data;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO results, busy window length,
// ignored starts while busy, operand isolation and mid-op reset.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_md_op;
    logic [31:0] E_rs_data;
    logic [31:0] E_rt_data;
    logic        E_md_busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    e_mdu dut (
        .clk       (clk),
        .reset     (reset),
        .E_start   (E_start),
        .E_md_op   (E_md_op),
        .E_rs_data (E_rs_data),
        .E_rt_data (E_rt_data),
        .E_md_busy (E_md_busy),
        .E_HI      (E_HI),
        .E_LO      (E_LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a MULT/DIV, scramble operands after acceptance, optionally poke
    // another start mid-flight, and check the busy window plus final HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input int n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit inject,
                          input logic [2:0] inj_op);
        E_start   = 1'b1;
        E_md_op   = op;
        E_rs_data = rs;
        E_rt_data = rt;
        tick();
        E_start   = 1'b0;
        E_rs_data = $urandom;
        E_rt_data = $urandom;
        for (int c = 0; c < n; c++) begin
            chk($sformatf("%s_busy%0d", tag, c), {31'd0, E_md_busy}, 32'd1);
            chk($sformatf("%s_hold_hi%0d", tag, c), E_HI, m_hi);
            chk($sformatf("%s_hold_lo%0d", tag, c), E_LO, m_lo);
            if (inject && c == 1) begin
                E_start = 1'b1;
                E_md_op = inj_op;
            end else begin
                E_start = 1'b0;
            end
            tick();
        end
        E_start = 1'b0;
        m_hi = exp_hi;
        m_lo = exp_lo;
        chk({tag, "_idle"}, {31'd0, E_md_busy}, 32'd0);
        chk({tag, "_hi"}, E_HI, m_hi);
        chk({tag, "_lo"}, E_LO, m_lo);
    endtask

    task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] val);
        E_start   = 1'b1;
        E_md_op   = op;
        E_rs_data = val;
        E_rt_data = $urandom;
        tick();
        E_start = 1'b0;
        if (op == 3'd4) m_hi = val;
        if (op == 3'd5) m_lo = val;
        chk({tag, "_busy"}, {31'd0, E_md_busy}, 32'd0);
        chk({tag, "_hi"}, E_HI, m_hi);
        chk({tag, "_lo"}, E_LO, m_lo);
        tick();
        chk({tag, "_busy2"}, {31'd0, E_md_busy}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        E_start   = 1'b0;
        E_md_op   = '0;
        E_rs_data = '0;
        E_rt_data = '0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, E_md_busy}, 32'd0);
        chk("rst_hi", E_HI, 32'd0);
        chk("rst_lo", E_LO, 32'd0);
        reset = 1'b0;

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 3'd0);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 3'd0);
        run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0, 1'b1, 3'd2);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 3'd0);
        run_op("divu_zero", 3'd3, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 3'd0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 1'b0, 3'd0);
        run_op("divu_mtlo", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1, 3'd5);

        mt_op("mthi", 3'd4, 32'h1234_5678);
        mt_op("mtlo", 3'd5, 32'hCAFE_F00D);
        mt_op("op6", 3'd6, 32'hDEAD_BEEF);
        mt_op("op7", 3'd7, 32'hBEEF_DEAD);

        run_op("div_negdiv", 3'd2, 32'd100, 32'hFFFF_FFF9, 10, 32'd2, 32'hFFFF_FFF2, 1'b1, 3'd4);

        // Reset in the third busy cycle of a DIV.
        E_start   = 1'b1;
        E_md_op   = 3'd2;
        E_rs_data = 32'd50;
        E_rt_data = 32'd3;
        tick();
        E_start = 1'b0;
        tick();
        tick();
        chk("rstmid_busy_pre", {31'd0, E_md_busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("rstmid_busy", {31'd0, E_md_busy}, 32'd0);
        chk("rstmid_hi", E_HI, 32'd0);
        chk("rstmid_lo", E_LO, 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk($sformatf("rstpost_busy%0d", c), {31'd0, E_md_busy}, 32'd0);
            chk($sformatf("rstpost_hi%0d", c), E_HI, 32'd0);
            chk($sformatf("rstpost_lo%0d", c), E_LO, 32'd0);
        end

        run_op("mult_after_rst", 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
